// File: rtl/pheap_level.sv
// pheap_level: one tree level (levels 2..LEVELS) of the pipelined heap.
// Each token from the parent level gets a fixed three-cycle slot:
//   IDLE (accept) -> READ (own entry and child pair settle) -> EXEC.
// EXEC does at most one write to the own entry, and may forward a token
// to the child level or raise an error pulse.
// Handshake: a token transfers on a rising edge where in_valid && in_ready.
// The parent holds the token while in_ready is low. out_valid is a
// one-cycle pulse with no back-pressure: the child stage is always back in
// IDLE by the time this stage can issue its next token.
// Entry layout: {priority[PW], capacity[CW], active}.
module pheap_level #(
  parameter int LEVELS = 4,
  parameter int LEVEL  = 2,
  parameter int PW     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_op,
  input  logic [PW-1:0]              in_value,
  input  logic [LEVEL-2:0]           in_pos,
  output logic                       out_valid,
  output logic                       out_op,
  output logic [PW-1:0]              out_value,
  output logic [LEVEL-1:0]           out_pos,
  input  logic [LEVEL-2:0]           par_raddr,
  output logic [PW+LEVELS:0]         par_rdataL,
  output logic [PW+LEVELS:0]         par_rdataR,
  output logic [LEVEL-1:0]           chd_raddr,
  input  logic [PW+LEVELS:0]         chd_rdataL,
  input  logic [PW+LEVELS:0]         chd_rdataR,
  output logic                       err_ovf,
  output logic                       err_udf,
  output logic [1:0]                 dbg_state
);

  localparam int CW = LEVELS;
  localparam int AW = LEVEL - 1;
  localparam int N  = 1 << AW;
  localparam int EW = PW + CW + 1;
  localparam logic [CW-1:0] CAP_RST = CW'((1 << (LEVELS - LEVEL + 1)) - 1);
  localparam logic OP_LEQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_EXEC} state_t;

  state_t        state;
  logic [AW-1:0] sweep_cnt;
  logic [AW-1:0] pos_q;
  logic          op_q;
  logic [PW-1:0] val_q;
  logic [EW-1:0] mem [N];

  // Own entry and child pair fields
  logic [EW-1:0] e;
  logic [PW-1:0] e_pri, l_pri, r_pri;
  logic [CW-1:0] e_cap, l_cap;
  logic          e_act, l_act, r_act;
  logic          sel;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [EW-1:0] wr_data;
  logic [AW-1:0] par_lo, par_hi;
  logic          unused_bits;

  assign e     = mem[pos_q];
  assign e_pri = e[EW-1 -: PW];
  assign e_cap = e[CW:1];
  assign e_act = e[0];
  assign l_pri = chd_rdataL[EW-1 -: PW];
  assign l_cap = chd_rdataL[CW:1];
  assign l_act = chd_rdataL[0];
  assign r_pri = chd_rdataR[EW-1 -: PW];
  assign r_act = chd_rdataR[0];
  // The right child's capacity never influences the decision.
  assign unused_bits = ^chd_rdataR[CW:1];

  // Right child wins only when it is active and strictly larger (or left is empty)
  assign sel = r_act && (!l_act || (r_pri > l_pri));

  assign par_lo    = par_raddr & ~AW'(1);
  assign par_hi    = par_lo | AW'(1);
  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;

  // Write port, token and error decode for INIT sweep and EXEC
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = pos_q;
    wr_data   = e;
    out_valid = 1'b0;
    out_op    = OP_LEQ;
    out_value = '0;
    out_pos   = '0;
    err_ovf   = 1'b0;
    err_udf   = 1'b0;
    if (!rst && state == S_INIT) begin
      wr_en   = 1'b1;
      wr_addr = sweep_cnt;
      wr_data = {PW'(0), CAP_RST, 1'b0};
    end else if (!rst && state == S_EXEC) begin
      if (op_q == OP_LEQ) begin
        if (e_cap == '0) begin
          err_ovf = 1'b1;
        end else if (!e_act) begin
          wr_en   = 1'b1;
          wr_data = {val_q, e_cap - CW'(1), 1'b1};
        end else begin
          // Larger value stays; on a tie the incoming value is pushed down
          wr_en     = 1'b1;
          wr_data   = {(val_q > e_pri) ? val_q : e_pri, e_cap - CW'(1), 1'b1};
          out_valid = 1'b1;
          out_op    = OP_LEQ;
          out_value = (val_q > e_pri) ? e_pri : val_q;
          out_pos   = {pos_q, (l_cap == '0)};
        end
      end else begin
        if (!e_act) begin
          err_udf = 1'b1;
        end else if (!l_act && !r_act) begin
          wr_en   = 1'b1;
          wr_data = {PW'(0), e_cap + CW'(1), 1'b0};
        end else begin
          wr_en     = 1'b1;
          wr_data   = {sel ? r_pri : l_pri, e_cap + CW'(1), 1'b1};
          out_valid = 1'b1;
          out_op    = OP_DEQ;
          out_pos   = {pos_q, sel};
        end
      end
    end
  end

  // Entry storage; contents are established by the post-reset sweep
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Parent read port, registered, write-first against this cycle's write
  always_ff @(posedge clk) begin
    if (rst) begin
      par_rdataL <= '0;
      par_rdataR <= '0;
    end else begin
      par_rdataL <= (wr_en && wr_addr == par_lo) ? wr_data : mem[par_lo];
      par_rdataR <= (wr_en && wr_addr == par_hi) ? wr_data : mem[par_hi];
    end
  end

  // Control FSM: sweep, accept, read, execute
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      chd_raddr <= '0;
      op_q      <= OP_LEQ;
      val_q     <= '0;
      pos_q     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          sweep_cnt <= sweep_cnt + AW'(1);
          if (sweep_cnt == AW'(N - 1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            val_q     <= in_value;
            pos_q     <= in_pos;
            chd_raddr <= {in_pos, 1'b0};
            state     <= S_READ;
          end
        end
        S_READ:  state <= S_EXEC;
        S_EXEC:  state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pheap_level.sv
// tb_pheap_level: directed vectors for a LEVELS=3, LEVEL=2, PW=8 stage.
module tb_pheap_level;

  localparam int LEVELS = 3;
  localparam int LEVEL  = 2;
  localparam int PW     = 8;
  localparam logic LEQ  = 1'b0;
  localparam logic DEQ  = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_op;
  logic [7:0]  in_value;
  logic [0:0]  in_pos;
  logic        out_valid, out_op;
  logic [7:0]  out_value;
  logic [1:0]  out_pos;
  logic [0:0]  par_raddr;
  logic [11:0] par_rdataL, par_rdataR;
  logic [1:0]  chd_raddr;
  logic [11:0] chd_rdataL, chd_rdataR;
  logic        err_ovf, err_udf;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  pheap_level #(.LEVELS(LEVELS), .LEVEL(LEVEL), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_value(in_value), .in_pos(in_pos),
    .out_valid(out_valid), .out_op(out_op), .out_value(out_value), .out_pos(out_pos),
    .par_raddr(par_raddr), .par_rdataL(par_rdataL), .par_rdataR(par_rdataR),
    .chd_raddr(chd_raddr), .chd_rdataL(chd_rdataL), .chd_rdataR(chd_rdataR),
    .err_ovf(err_ovf), .err_udf(err_udf), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [11:0] ent(input logic [7:0] pri, input logic [2:0] cap, input logic act);
    return {pri, cap, act};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_chd(input logic [11:0] l, input logic [11:0] r);
    chd_rdataL = l;
    chd_rdataR = r;
  endtask

  // Called at a negedge with the stage idle; reads one entry through the parent port
  task automatic read_entry(input string tag, input logic addr, input logic [11:0] exp);
    par_raddr = addr;
    @(negedge clk);
    check(tag, addr ? par_rdataR : par_rdataL, exp);
  endtask

  // Called at a negedge with the stage idle; runs one token through IDLE/READ/EXEC
  task automatic run_op(input string tag, input logic op, input logic [7:0] val, input logic pos,
                        input logic ev, input logic eop, input logic [7:0] evalue,
                        input logic [1:0] epos, input logic eovf, input logic eudf);
    check({tag, " ready"}, in_ready, 1);
    in_valid = 1'b1; in_op = op; in_value = val; in_pos = pos;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " read quiet"}, {out_valid, err_ovf, err_udf}, 0);
    check({tag, " chd_raddr"}, chd_raddr, {pos, 1'b0});
    @(negedge clk);
    check({tag, " out_valid"}, out_valid, ev);
    check({tag, " out_op"}, out_op, eop);
    check({tag, " out_value"}, out_value, evalue);
    check({tag, " out_pos"}, out_pos, epos);
    check({tag, " err_ovf"}, err_ovf, eovf);
    check({tag, " err_udf"}, err_udf, eudf);
    @(negedge clk);
    check({tag, " after quiet"}, {out_valid, err_ovf, err_udf, in_ready}, 1);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = LEQ; in_value = '0; in_pos = '0;
    par_raddr = '0; chd_rdataL = '0; chd_rdataR = '0;
    @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst outs", {out_valid, out_op, out_value, out_pos}, 0);
    check("rst chd_raddr", chd_raddr, 0);
    check("rst errs", {err_ovf, err_udf}, 0);
    check("rst par_rdata", {par_rdataL, par_rdataR}, 0);
    check("rst state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("sweep ready0", in_ready, 0);
    check("sweep rdL during init", par_rdataL, ent(8'h00, 3'd3, 1'b0));
    @(negedge clk);
    check("sweep ready1", in_ready, 1);
    check("sweep rdL", par_rdataL, ent(8'h00, 3'd3, 1'b0));
    check("sweep rdR", par_rdataR, ent(8'h00, 3'd3, 1'b0));

    // Insert into empty entry
    set_chd(12'h000, 12'h000);
    run_op("ins_empty", LEQ, 8'h20, 1'b1, 0, LEQ, 8'h00, 2'd0, 0, 0);
    read_entry("ins_empty e1", 1'b1, ent(8'h20, 3'd2, 1'b1));

    // Push-down to left child (left has room)
    set_chd(ent(8'h00, 3'd1, 1'b0), 12'h000);
    run_op("push", LEQ, 8'h30, 1'b1, 1, LEQ, 8'h20, 2'd2, 0, 0);
    read_entry("push e1", 1'b1, ent(8'h30, 3'd1, 1'b1));

    // Push-down to right child (left full), smaller incoming value goes down
    set_chd(ent(8'h00, 3'd0, 1'b0), 12'h000);
    run_op("push_r", LEQ, 8'h10, 1'b1, 1, LEQ, 8'h10, 2'd3, 0, 0);
    read_entry("push_r e1", 1'b1, ent(8'h30, 3'd0, 1'b1));

    // Overflow on a full entry
    run_op("ovf", LEQ, 8'h40, 1'b1, 0, LEQ, 8'h00, 2'd0, 1, 0);
    read_entry("ovf e1", 1'b1, ent(8'h30, 3'd0, 1'b1));

    // Underflow on an inactive entry
    run_op("udf", DEQ, 8'h00, 1'b0, 0, LEQ, 8'h00, 2'd0, 0, 1);
    read_entry("udf e0", 1'b0, ent(8'h00, 3'd3, 1'b0));

    // Fill entry0 to capacity 0, including a tie
    set_chd(ent(8'h00, 3'd1, 1'b0), 12'h000);
    run_op("fill1", LEQ, 8'h50, 1'b0, 0, LEQ, 8'h00, 2'd0, 0, 0);
    run_op("fill2", LEQ, 8'h05, 1'b0, 1, LEQ, 8'h05, 2'd0, 0, 0);
    set_chd(ent(8'h00, 3'd0, 1'b0), 12'h000);
    run_op("fill_tie", LEQ, 8'h50, 1'b0, 1, LEQ, 8'h50, 2'd1, 0, 0);
    read_entry("fill e0", 1'b0, ent(8'h50, 3'd0, 1'b1));

    // Dequeue refill from the larger child
    set_chd(ent(8'h11, 3'd1, 1'b1), ent(8'h15, 3'd1, 1'b1));
    run_op("deq", DEQ, 8'h00, 1'b0, 1, DEQ, 8'h00, 2'd1, 0, 0);
    read_entry("deq e0", 1'b0, ent(8'h15, 3'd1, 1'b1));

    // Dequeue with both children empty
    set_chd(ent(8'h00, 3'd1, 1'b0), ent(8'h00, 3'd1, 1'b0));
    run_op("deq_empty", DEQ, 8'h00, 1'b0, 0, LEQ, 8'h00, 2'd0, 0, 0);
    read_entry("deq_empty e0", 1'b0, ent(8'h00, 3'd2, 1'b0));

    // Inactive right child with larger priority must lose
    run_op("refill", LEQ, 8'h60, 1'b0, 0, LEQ, 8'h00, 2'd0, 0, 0);
    set_chd(ent(8'h09, 3'd1, 1'b1), ent(8'h40, 3'd1, 1'b0));
    run_op("deq_rinact", DEQ, 8'h00, 1'b0, 1, DEQ, 8'h00, 2'd0, 0, 0);
    read_entry("deq_rinact e0", 1'b0, ent(8'h09, 3'd2, 1'b1));

    // Equal children: left wins
    set_chd(ent(8'h22, 3'd1, 1'b1), ent(8'h22, 3'd1, 1'b1));
    run_op("deq_tie", DEQ, 8'h00, 1'b0, 1, DEQ, 8'h00, 2'd0, 0, 0);
    read_entry("deq_tie e0", 1'b0, ent(8'h22, 3'd3, 1'b1));

    // Inactive left child: right wins
    set_chd(ent(8'h70, 3'd0, 1'b0), ent(8'h03, 3'd1, 1'b1));
    run_op("deq_linact", DEQ, 8'h00, 1'b0, 1, DEQ, 8'h00, 2'd1, 0, 0);
    read_entry("deq_linact e0", 1'b0, ent(8'h03, 3'd4, 1'b1));

    // Reset while a token is in READ
    set_chd(12'h000, 12'h000);
    check("rstmid ready", in_ready, 1);
    in_valid = 1'b1; in_op = LEQ; in_value = 8'h77; in_pos = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid pulses", {out_valid, err_ovf, err_udf}, 0);
    check("rstmid ready0", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid pulses2", {out_valid, err_ovf, err_udf}, 0);
    check("rstmid ready1", in_ready, 0);
    @(negedge clk);
    check("rstmid ready2", in_ready, 1);
    read_entry("rstmid e0", 1'b0, ent(8'h00, 3'd3, 1'b0));
    read_entry("rstmid e1", 1'b1, ent(8'h00, 3'd3, 1'b0));

    // Write-first bypass on the parent read port
    par_raddr = 1'b1;
    run_op("bypass", LEQ, 8'h20, 1'b1, 0, LEQ, 8'h00, 2'd0, 0, 0);
    check("bypass rdR", par_rdataR, ent(8'h20, 3'd2, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pheap_level.md
# pheap_level

Generic, parametrised level stage of the pipelined heap (P-heap) for levels 2..LEVELS; the top level stays in its dedicated block. Each instance owns the 2^(LEVEL-1) entries of one tree level. It accepts one enqueue/dequeue token from the level above, updates its own entry, and forwards a token to the level below. It also serves the two-entry child read for the parent level and self-initialises its storage after reset.

## Interface
- LEVELS, 4: total heap depth; sets capacity width CW = LEVELS.
- LEVEL, 2: this stage's level, 2 <= LEVEL <= LEVELS; N = 2^(LEVEL-1) entries, AW = LEVEL-1 address bits.
- PW, 32: priority width; entry layout {priority[PW], capacity[CW], active}, identical to pheapTypes::entry_t when PW=32.

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  token from parent
- in_ready  out  1  stage can accept a token
- in_op  in  pheapTypes::opcode_t  LEQ or DEQ
- in_value  in  PW  value to insert (LEQ); ignored for DEQ
- in_pos  in  AW  entry index in this level
- out_valid  out  1  token to child level, one-cycle pulse
- out_op  out  opcode_t  forwarded op
- out_value  out  PW  value pushed down (LEQ)
- out_pos  out  AW+1  child entry index
- par_raddr  in  AW  parent read address; bit 0 ignored
- par_rdataL / par_rdataR  out  entry  entries {par_raddr[AW-1:1],0} and {...,1}
- chd_raddr  out  AW+1  child pair read address = 2*in_pos
- chd_rdataL / chd_rdataR  in  entry  child pair; tied all-zero when LEVEL==LEVELS
- err_ovf / err_udf  out  1  one-cycle error pulses

## Operation
- States: INIT, IDLE, READ, EXEC.
- INIT:
  - Entered on rst.
  - Sweeps addr 0..N-1, one entry per cycle, writing {0, 2^(LEVELS-LEVEL+1)-1, 0}.
  - Goes to IDLE after the last write. in_ready stays 0 throughout.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready latches op/value/pos, drives chd_raddr=2*in_pos, starts the own-entry read, and goes to READ.
- READ:
  - The own entry E and the child pair L/R are valid at the end of this cycle. Next state EXEC.
- EXEC: one write to E, then IDLE. Cases:
  - LEQ, E.capacity==0: no write, no token, err_ovf=1.
  - LEQ, !E.active: E <= {in_value, cap-1, 1}. No token.
  - LEQ, E.active: E keeps max(E.priority, in_value), cap-1, active=1.
    - Token out_op=LEQ, out_value = the smaller value (tie: in_value pushed down).
    - out_pos = 2*pos + (L.capacity!=0 ? 0 : 1).
  - DEQ, !E.active: no write, no token, err_udf=1.
  - DEQ, !L.active && !R.active: E <= {0, cap+1, 0}. No token.
  - DEQ otherwise: E.priority <= the larger active child (tie/only-left: L), cap+1, active=1.
    - Token out_op=DEQ, out_pos = 2*pos + sel.
    - An inactive child's priority counts as smaller.
- Capacity arithmetic is unsigned CW-bit and never wraps: the error cases block decrement at 0. Increment is bounded by the reset value by construction.
- Parent read port:
  - par_rdataL/R registered, 1-cycle latency.
  - Write-first: an EXEC write to a read address in the same cycle returns the new data.
  - Served in every state; during INIT it returns the reset entry for already-swept addresses.

## Timing
- Reset values: in_ready=0, out_valid=0, out_op=LEQ, out_value=0, out_pos=0, chd_raddr=0, err_*=0, par_rdata*=0. State=INIT, sweep counter=0.
- First in_ready=1 at N cycles after rst deasserts.
- Throughput: one token per 3 cycles (IDLE→READ→EXEC).
- Latency: accept at edge t, out_valid/err pulse during cycle t+2.
- out_valid, out_op/value/pos and err_* are valid only in the EXEC cycle and are 0 otherwise.
- in_valid while in_ready=0: ignored. The parent holds the token.
- rst mid-operation: the in-flight token is dropped with no write and no pulse, and the sweep restarts at 0.

## Test plan
Configuration for all scenarios: LEVELS=3, LEVEL=2, PW=8, N=2.
- Reset sweep: rst 1 cycle → in_ready rises 2 cycles later. par_raddr=0 reads {0,3,0} on both ports.
- Insert into empty: LEQ val 0x20 pos 1 → entry1={0x20,2,1}, no out_valid, no errors.
- Push-down: entry1={0x20,2,1}, LEQ 0x30 pos 1, chd L.cap=1 → entry1={0x30,1,1}, out LEQ 0x20 pos 2, pulse at t+2.
- Dequeue refill: entry0 active cap 0, L={0x11,1,1}, R={0x15,1,1}, DEQ pos 0 → entry0={0x15,1,1}, out DEQ pos 1. Repeat with both children inactive → entry0={0,2,0}, no token.
- Errors: LEQ on entry cap 0 → err_ovf, entry unchanged. DEQ on inactive entry → err_udf, no write.
- Reset in READ → no write, no pulses, in_ready=0 for 2 cycles. Bypass: parent read of pos 1 during EXEC returns the new entry.
